// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit: eight ops on two WIDTH-bit operands, optional accumulate,
// one-deep valid/ready output stage and a completed-handshake counter.
module bitwise_logic_unit #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             all_ones,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] txn_cnt
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             all_ones_q, all_ones_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             handshake;
   logic [WIDTH-1:0] acc_eff;
   logic [WIDTH-1:0] opnd_y;
   logic [WIDTH-1:0] result;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign handshake = out_valid_q && out_ready;

   // A same-cycle clear is consumed by the operand rather than applied afterwards.
   assign acc_eff = acc_clr ? '0 : acc_q;
   assign opnd_y  = acc_mode ? acc_eff : b;

   always_comb begin
      result = a;
      unique case (op)
         3'd0: result = a & opnd_y;
         3'd1: result = a | opnd_y;
         3'd2: result = a ^ opnd_y;
         3'd3: result = ~(a & opnd_y);
         3'd4: result = ~(a | opnd_y);
         3'd5: result = ~(a ^ opnd_y);
         3'd6: result = a & ~opnd_y;
         3'd7: result = a;
         default: result = a;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      y_d         = y_q;
      zero_d      = zero_q;
      all_ones_d  = all_ones_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;

      if (accept) begin
         out_valid_d = 1'b1;
         y_d         = result;
         zero_d      = (result == '0);
         all_ones_d  = &result;
      end else if (handshake) begin
         out_valid_d = 1'b0;
      end

      if (handshake) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (accept && acc_mode) begin
         acc_d = result;
      end else if (acc_clr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         zero_q      <= 1'b1;
         all_ones_q  <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         all_ones_q  <= all_ones_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign zero      = zero_q;
   assign all_ones  = all_ones_q;
   assign acc       = acc_q;
   assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed bench for bitwise_logic_unit: a WIDTH=4/CNT_W=8 unit plus a CNT_W=2 twin
// sharing the same inputs to observe counter wrap.
module tb_bitwise_logic_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] op;
   logic       acc_mode;
   logic       acc_clr;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] y;
   logic       zero;
   logic       all_ones;
   logic [3:0] acc;
   logic [7:0] txn_cnt;

   logic       w_in_ready;
   logic       w_out_valid;
   logic [3:0] w_y;
   logic       w_zero;
   logic       w_all_ones;
   logic [3:0] w_acc;
   logic [1:0] w_txn_cnt;

   int checks = 0;
   int errors = 0;

   bitwise_logic_unit #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr), .out_valid(out_valid),
      .out_ready(out_ready), .y(y), .zero(zero), .all_ones(all_ones), .acc(acc),
      .txn_cnt(txn_cnt)
   );

   bitwise_logic_unit #(.WIDTH(4), .CNT_W(2)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .a(a), .b(b),
      .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr), .out_valid(w_out_valid),
      .out_ready(out_ready), .y(w_y), .zero(w_zero), .all_ones(w_all_ones), .acc(w_acc),
      .txn_cnt(w_txn_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] sweep_exp [8];
      logic [1:0] wrap_exp [5];
      sweep_exp = '{4'h8, 4'hE, 4'h6, 4'h7, 4'h1, 4'h9, 4'h4, 4'hC};
      wrap_exp  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
      acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_out_valid", 16'(out_valid), 16'h0);
      chk("rst_y", 16'(y), 16'h0);
      chk("rst_zero", 16'(zero), 16'h1);
      chk("rst_all_ones", 16'(all_ones), 16'h0);
      chk("rst_acc", 16'(acc), 16'h0);
      chk("rst_txn", 16'(txn_cnt), 16'h0);
      chk("rst_in_ready", 16'(in_ready), 16'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Op sweep, full throughput
      in_valid = 1'b1; a = 4'hC; b = 4'hA; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         tick();
         chk($sformatf("sweep_valid_%0d", i), 16'(out_valid), 16'h1);
         chk($sformatf("sweep_y_%0d", i), 16'(y), 16'(sweep_exp[i]));
      end
      in_valid = 1'b0;
      tick();
      chk("sweep_txn", 16'(txn_cnt), 16'd8);
      chk("sweep_drain_valid", 16'(out_valid), 16'h0);

      // Backpressure
      in_valid = 1'b1; a = 4'hF; b = 4'hF; op = 3'd0; out_ready = 1'b0;
      tick();
      chk("bp_y", 16'(y), 16'hF);
      chk("bp_all_ones", 16'(all_ones), 16'h1);
      chk("bp_in_ready", 16'(in_ready), 16'h0);
      for (int i = 0; i < 3; i++) begin
         a = 4'(i); b = 4'(3 - i); op = 3'(i + 1);
         tick();
         chk($sformatf("bp_stall_y_%0d", i), 16'(y), 16'hF);
         chk($sformatf("bp_stall_ones_%0d", i), 16'(all_ones), 16'h1);
         chk($sformatf("bp_stall_valid_%0d", i), 16'(out_valid), 16'h1);
         chk($sformatf("bp_stall_rdy_%0d", i), 16'(in_ready), 16'h0);
      end
      chk("bp_txn_hold", 16'(txn_cnt), 16'd8);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("bp_release_txn", 16'(txn_cnt), 16'd9);
      chk("bp_release_valid", 16'(out_valid), 16'h0);

      // Accumulate (b ignored)
      in_valid = 1'b1; acc_mode = 1'b1; acc_clr = 1'b1; op = 3'd1; a = 4'h1; b = 4'hF;
      tick();
      chk("acc1_acc", 16'(acc), 16'h1);
      chk("acc1_y", 16'(y), 16'h1);
      acc_clr = 1'b0; a = 4'h4;
      tick();
      chk("acc2_acc", 16'(acc), 16'h5);
      chk("acc2_y", 16'(y), 16'h5);
      a = 4'h8;
      tick();
      chk("acc3_acc", 16'(acc), 16'hD);
      chk("acc3_y", 16'(y), 16'hD);
      chk("acc_txn", 16'(txn_cnt), 16'd11);

      // Clear consumed by operand, then standalone clear
      op = 3'd2; a = 4'h3; acc_clr = 1'b1;
      tick();
      chk("clrpri_y", 16'(y), 16'h3);
      chk("clrpri_acc", 16'(acc), 16'h3);
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
      chk("clr_alone_acc", 16'(acc), 16'h0);
      chk("clr_alone_valid", 16'(out_valid), 16'h1);
      chk("clr_alone_y", 16'(y), 16'h3);
      acc_clr = 1'b0;

      // Reset in the middle of a stall
      in_valid = 1'b1; out_ready = 1'b1; acc_mode = 1'b1; op = 3'd7; a = 4'hA;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
      chk("pre_rst_y", 16'(y), 16'hA);
      chk("pre_rst_acc", 16'(acc), 16'hA);
      chk("pre_rst_txn", 16'(txn_cnt), 16'd13);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 16'(out_valid), 16'h0);
      chk("arst_y", 16'(y), 16'h0);
      chk("arst_zero", 16'(zero), 16'h1);
      chk("arst_acc", 16'(acc), 16'h0);
      chk("arst_txn", 16'(txn_cnt), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_in_ready", 16'(in_ready), 16'h1);

      // Counter wrap on the CNT_W=2 twin
      in_valid = 1'b1; out_ready = 1'b1; acc_mode = 1'b0; op = 3'd0; a = 4'h5; b = 4'hA;
      tick();
      chk("wrap_zero", 16'(w_zero), 16'h1);
      chk("wrap_y", 16'(w_y), 16'h0);
      chk("wrap_start", 16'(w_txn_cnt), 16'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("wrap_cnt_%0d", i), 16'(w_txn_cnt), 16'(wrap_exp[i]));
         chk($sformatf("wrap_main_%0d", i), 16'(txn_cnt), 16'(i + 1));
      end
      in_valid = 1'b0;
      tick();
      chk("wrap_final_valid", 16'(w_out_valid), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
